mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb.sv | 137 +++++++++++++
 tb/tb_mem_arb.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// mem_arb: arbitrates dbg, cpu data write/read and instruction read onto one sync SRAM port
// Optional feature macro ARB_FAIR_EN: alternate grants between instruction and data classes
module mem_arb #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] ins_rd_addr,
  input  logic          ins_rd_req,
  output logic          ins_rd_rdy,
  output logic [DW-1:0] ins_rd_data,
  input  logic [AW-1:0] dat_rw_addr,
  input  logic          dat_rd_req,
  output logic          dat_rd_rdy,
  output logic [DW-1:0] dat_rd_data,
  input  logic [DW-1:0] dat_wr_data,
  input  logic          dat_wr_req,
  output logic          dat_wr_rdy,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_waddr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } ch_st_t;

  ch_st_t ins_st, ins_nx;
  ch_st_t rd_st, rd_nx;
  ch_st_t wr_st, wr_nx;

  logic ins_el, rd_el, wr_el;
  logic g_ins, g_rd, g_wr;

`ifdef ARB_FAIR_EN
  logic data_el;
  logic last_ins, last_ins_nx;
`endif

  // Per-channel state and fairness flag; reset drops any access in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ins_st   <= IDLE;
      rd_st    <= IDLE;
      wr_st    <= IDLE;
`ifdef ARB_FAIR_EN
      last_ins <= 1'b0;
`endif
    end else begin
      ins_st   <= ins_nx;
      rd_st    <= rd_nx;
      wr_st    <= wr_nx;
`ifdef ARB_FAIR_EN
      last_ins <= last_ins_nx;
`endif
    end
  end

  // Eligibility, grant selection and next state
  always_comb begin
    wr_el  = dat_wr_req && (wr_st == IDLE);
    rd_el  = dat_rd_req && (rd_st == IDLE) && !dat_wr_req;
    ins_el = ins_rd_req && (ins_st == IDLE);
    g_wr   = 1'b0;
    g_rd   = 1'b0;
    g_ins  = 1'b0;
`ifdef ARB_FAIR_EN
    data_el     = wr_el || rd_el;
    last_ins_nx = last_ins;
    if (!dbg_we) begin
      if (data_el && (!ins_el || last_ins)) begin
        g_wr = wr_el;
        g_rd = !wr_el;
      end else begin
        g_ins = ins_el;
      end
    end
    if (g_ins) begin
      last_ins_nx = 1'b1;
    end else if (g_wr || g_rd) begin
      last_ins_nx = 1'b0;
    end
`else
    if (!dbg_we) begin
      g_wr  = wr_el;
      g_rd  = rd_el;
      g_ins = ins_el && !dat_wr_req && !dat_rd_req;
    end
`endif
    wr_nx  = g_wr  ? GRANTED : IDLE;
    rd_nx  = g_rd  ? GRANTED : IDLE;
    ins_nx = g_ins ? GRANTED : IDLE;
  end

  // SRAM port steering; the winner owns the port this cycle
  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = ins_rd_addr;
    mem_wdata = dat_wr_data;
    if (reset_n) begin
      unique case (1'b1)
        dbg_we: begin
          mem_we    = 1'b1;
          mem_addr  = dbg_waddr;
          mem_wdata = dbg_wdata;
        end
        g_wr: begin
          mem_we   = 1'b1;
          mem_addr = dat_rw_addr;
        end
        g_rd: begin
          mem_re   = 1'b1;
          mem_addr = dat_rw_addr;
        end
        g_ins: begin
          mem_re   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ins_rd_rdy  = (ins_st == GRANTED);
  assign dat_rd_rdy  = (rd_st == GRANTED);
  assign dat_wr_rdy  = (wr_st == GRANTED);
  assign ins_rd_data = mem_rdata;
  assign dat_rd_data = mem_rdata;

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed and random checks of mem_arb against a behavioural model
// Honours ARB_FAIR_EN the same way as the design
module tb_mem_arb;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] ins_rd_addr = '0;
  logic          ins_rd_req = 1'b0;
  logic          ins_rd_rdy;
  logic [DW-1:0] ins_rd_data;
  logic [AW-1:0] dat_rw_addr = '0;
  logic          dat_rd_req = 1'b0;
  logic          dat_rd_rdy;
  logic [DW-1:0] dat_rd_data;
  logic [DW-1:0] dat_wr_data = '0;
  logic          dat_wr_req = 1'b0;
  logic          dat_wr_rdy;
  logic          dbg_we = 1'b0;
  logic [AW-1:0] dbg_waddr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_arb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .ins_rd_addr(ins_rd_addr), .ins_rd_req(ins_rd_req),
    .ins_rd_rdy(ins_rd_rdy), .ins_rd_data(ins_rd_data),
    .dat_rw_addr(dat_rw_addr), .dat_rd_req(dat_rd_req),
    .dat_rd_rdy(dat_rd_rdy), .dat_rd_data(dat_rd_data),
    .dat_wr_data(dat_wr_data), .dat_wr_req(dat_wr_req),
    .dat_wr_rdy(dat_wr_rdy),
    .dbg_we(dbg_we), .dbg_waddr(dbg_waddr), .dbg_wdata(dbg_wdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  logic [DW-1:0] sram   [0:65535];
  logic [DW-1:0] shadow [0:65535];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // synchronous SRAM: controls captured mid-cycle, applied at the edge
  initial begin : sram_p
    logic          we_q, re_q;
    logic [AW-1:0] a_q;
    logic [DW-1:0] d_q;
    for (int i = 0; i < 256; i++) sram[i] = 16'(i * 257) ^ 16'h5a3c;
    sram[16'h10] = 16'h1234;
    forever begin
      @(negedge clk);
      we_q = mem_we; re_q = mem_re; a_q = mem_addr; d_q = mem_wdata;
      @(posedge clk);
      if (we_q) sram[a_q] = d_q;
      if (re_q) mem_rdata = sram[a_q];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ins_at = -1, rd_at = -1, wr_at = -1;
  logic [DW-1:0] ins_exp, rd_exp;
  logic ins_seen = 1'b0, rd_seen = 1'b0, wr_seen = 1'b0;

  // reference model: one rdy exactly one cycle after each grant, priority by rules
  initial begin : model
    int g;
    logic wr_e, rd_e, ins_e, last_ins;
    last_ins = 1'b0;
    forever begin
      @(negedge clk);
      ins_seen = ins_rd_rdy; rd_seen = dat_rd_rdy; wr_seen = dat_wr_rdy;
      if (!reset_n) begin
        ins_at = -1; rd_at = -1; wr_at = -1; last_ins = 1'b0;
        chk("reset_outs", {ins_rd_rdy, dat_rd_rdy, dat_wr_rdy, mem_we, mem_re}, 0);
      end else begin
        chk("ins_rdy", ins_rd_rdy, ins_at == cyc);
        chk("rd_rdy", dat_rd_rdy, rd_at == cyc);
        chk("wr_rdy", dat_wr_rdy, wr_at == cyc);
        if (ins_at == cyc) chk("ins_data", ins_rd_data, ins_exp);
        if (rd_at == cyc) chk("rd_data", dat_rd_data, rd_exp);
        wr_e  = dat_wr_req && (wr_at != cyc);
        rd_e  = dat_rd_req && (rd_at != cyc) && !dat_wr_req;
        ins_e = ins_rd_req && (ins_at != cyc);
        g = 0;
        if (dbg_we) g = 1;
        else begin
`ifdef ARB_FAIR_EN
          if ((wr_e || rd_e) && ins_e) g = last_ins ? (wr_e ? 2 : 3) : 4;
          else if (wr_e) g = 2;
          else if (rd_e) g = 3;
          else if (ins_e) g = 4;
`else
          if (wr_e) g = 2;
          else if (rd_e) g = 3;
          else if (ins_e && !dat_wr_req && !dat_rd_req) g = 4;
`endif
        end
        chk("mem_we", mem_we, (g == 1) || (g == 2));
        chk("mem_re", mem_re, (g == 3) || (g == 4));
        case (g)
          1: begin
            chk("dbg_addr", mem_addr, dbg_waddr);
            chk("dbg_wdata", mem_wdata, dbg_wdata);
            shadow[dbg_waddr] = dbg_wdata;
          end
          2: begin
            chk("wr_addr", mem_addr, dat_rw_addr);
            chk("wr_wdata", mem_wdata, dat_wr_data);
            shadow[dat_rw_addr] = dat_wr_data;
            wr_at = cyc + 1; last_ins = 1'b0;
          end
          3: begin
            chk("rd_addr", mem_addr, dat_rw_addr);
            rd_exp = shadow[dat_rw_addr];
            rd_at = cyc + 1; last_ins = 1'b0;
          end
          4: begin
            chk("ins_addr", mem_addr, ins_rd_addr);
            ins_exp = shadow[ins_rd_addr];
            ins_at = cyc + 1; last_ins = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  initial begin : stim
    int ni, nd, r;
    for (int i = 0; i < 256; i++) shadow[i] = 16'(i * 257) ^ 16'h5a3c;
    shadow[16'h10] = 16'h1234;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rdy", {ins_rd_rdy, dat_rd_rdy, dat_wr_rdy}, 0);

    // single instruction read right after reset release
    tick;
    reset_n = 1'b1; ins_rd_addr = 16'h0010; ins_rd_req = 1'b1;
    @(negedge clk);
    chk("t28_re", mem_re, 1);
    chk("t28_addr", mem_addr, 16'h0010);
    tick;
    @(negedge clk);
    chk("t28_rdy", ins_rd_rdy, 1);
    chk("t28_data", ins_rd_data, 16'h1234);
    tick;
    ins_rd_req = 1'b0;
    @(negedge clk);
    chk("t28_rdy_once", ins_rd_rdy, 0);

    // write then read back
    tick;
    dat_rw_addr = 16'h0020; dat_wr_data = 16'hbeef; dat_wr_req = 1'b1;
    @(negedge clk);
    chk("t29_we", {mem_we, mem_re}, 2'b10);
    tick;
    @(negedge clk);
    chk("t29_wr_rdy", dat_wr_rdy, 1);
    tick;
    dat_wr_req = 1'b0; dat_rd_req = 1'b1;
    @(negedge clk);
    chk("t29_re", {mem_we, mem_re}, 2'b01);
    tick;
    @(negedge clk);
    chk("t29_rd_rdy", dat_rd_rdy, 1);
    chk("t29_data", dat_rd_data, 16'hbeef);
    tick;
    dat_rd_req = 1'b0;

    // debug strobe for three cycles blocks a held cpu write
    tick;
    dat_rw_addr = 16'h0030; dat_wr_data = 16'h5a5a; dat_wr_req = 1'b1;
    dbg_we = 1'b1; dbg_waddr = 16'h0040; dbg_wdata = 16'h0f0f;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t30_no_rdy", dat_wr_rdy, 0);
      chk("t30_dbg_addr", mem_addr, 16'h0040);
      tick;
    end
    dbg_we = 1'b0;
    @(negedge clk);
    chk("t30_cpu_we", {mem_we, mem_addr}, {1'b1, 16'h0030});
    tick;
    @(negedge clk);
    chk("t30_wr_rdy", dat_wr_rdy, 1);
    tick;
    dat_wr_req = 1'b0;

    // read and write together: write first
    tick;
    dat_rw_addr = 16'h0050; dat_wr_data = 16'h7777;
    dat_wr_req = 1'b1; dat_rd_req = 1'b1;
    @(negedge clk);
    chk("t33_we", {mem_we, mem_re}, 2'b10);
    tick;
    @(negedge clk);
    chk("t33_wr_rdy", {dat_wr_rdy, mem_re}, 2'b10);
    tick;
    dat_wr_req = 1'b0;
    @(negedge clk);
    chk("t33_re", mem_re, 1);
    tick;
    @(negedge clk);
    chk("t33_data", {dat_rd_rdy, dat_rd_data}, {1'b1, 16'h7777});
    tick;
    dat_rd_req = 1'b0;

    // instruction and data read both held for 20 cycles
    tick;
    ins_rd_addr = 16'h0011; dat_rw_addr = 16'h0022;
    ins_rd_req = 1'b1; dat_rd_req = 1'b1;
    ni = 0; nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_re && mem_addr == 16'h0011) ni++;
      if (mem_re && mem_addr == 16'h0022) nd++;
      tick;
    end
    ins_rd_req = 1'b0; dat_rd_req = 1'b0;
`ifdef ARB_FAIR_EN
    chk("t31_ins_grants", ni, 10);
    chk("t31_dat_grants", nd, 10);
`else
    chk("t31_ins_grants", ni, 0);
    chk("t31_dat_grants", nd, 10);
`endif
    tick;
    tick;

    // reset between read grant and rdy
    dat_rw_addr = 16'h0020; dat_rd_req = 1'b1;
    @(negedge clk);
    chk("t32_re", mem_re, 1);
    #1 reset_n = 1'b0;
    @(negedge clk);
    chk("t32_outs", {dat_rd_rdy, mem_we, mem_re}, 0);
    tick;
    reset_n = 1'b1;
    @(negedge clk);
    chk("t32_no_rdy", dat_rd_rdy, 0);
    chk("t32_regrant", mem_re, 1);
    tick;
    @(negedge clk);
    chk("t32_data", {dat_rd_rdy, dat_rd_data}, {1'b1, 16'hbeef});
    tick;
    dat_rd_req = 1'b0;
    tick;

    // random traffic from all four sources
    repeat (3000) begin
      tick;
      if (ins_rd_req && ins_seen) ins_rd_req = 1'b0;
      else if (!ins_rd_req && $urandom_range(3) == 0) begin
        ins_rd_req = 1'b1; ins_rd_addr = 16'($urandom_range(255));
      end
      if (dat_wr_req && wr_seen) dat_wr_req = 1'b0;
      if (dat_rd_req && rd_seen) dat_rd_req = 1'b0;
      if (!dat_wr_req && !dat_rd_req) begin
        r = int'($urandom_range(7));
        if (r < 3) begin
          dat_rw_addr = 16'($urandom_range(255));
          dat_wr_data = 16'($urandom);
          dat_wr_req = (r != 1);
          dat_rd_req = (r != 0);
        end
      end
      dbg_we = ($urandom_range(7) == 0);
      dbg_waddr = 16'($urandom_range(255));
      dbg_wdata = 16'($urandom);
    end
    tick;
    ins_rd_req = 1'b0; dat_rd_req = 1'b0; dat_wr_req = 1'b0; dbg_we = 1'b0;
    repeat (4) tick;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
